// File: rtl/bcd_pkg.sv
// bcd_pkg: shared digit width, decoder state encoding and digit legality helper
package bcd_pkg;
    localparam int BCD_DIGIT_W = 4;

    typedef enum logic [1:0] {IDLE, CONV, DONE} bcd_dec_state_t;

    function automatic logic is_bcd_digit(input logic [3:0] d);
        return d <= 4'd9;
    endfunction
endpackage

// File: rtl/bcd_digit_adj.sv
// bcd_digit_adj: reverse double-dabble digit correction, subtract 3 when d >= 8
module bcd_digit_adj (
    input  logic [3:0] d,
    output logic [3:0] q
);
    always_comb q = (d >= 4'd8) ? d - 4'd3 : d;
endmodule

// File: rtl/bcd_decoder_seq.sv
// bcd_decoder_seq: serial reverse double-dabble BCD-to-binary decoder over valid/ready
// Define BCD_CHECK_EN to flag illegal digits on out_err and force out_bin to 0.
module bcd_decoder_seq
    import bcd_pkg::*;
#(
    parameter int NUM_DIGITS = 2,
    localparam int BIN_W = $clog2(10**NUM_DIGITS)
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              in_valid,
    output logic                              in_ready,
    input  logic [BCD_DIGIT_W*NUM_DIGITS-1:0] in_bcd,
    output logic                              out_valid,
    input  logic                              out_ready,
    output logic [BIN_W-1:0]                  out_bin,
    output logic                              out_err
);
    localparam int BW = BCD_DIGIT_W * NUM_DIGITS;
    localparam int CW = $clog2(BIN_W + 1);
    localparam logic [CW-1:0] LAST = CW'(BIN_W - 1);

    bcd_dec_state_t   state;
    logic [BW-1:0]    bcd_reg, bcd_shift, bcd_next;
    logic [BIN_W-1:0] bin_reg, bin_next;
    logic [CW-1:0]    cnt;

    assign bcd_shift = {1'b0, bcd_reg[BW-1:1]};
    assign bin_next  = {bcd_reg[0], bin_reg[BIN_W-1:1]};

    genvar i;
    for (i = 0; i < NUM_DIGITS; i++) begin : g_dig
        bcd_digit_adj u_adj (
            .d(bcd_shift[i*BCD_DIGIT_W +: BCD_DIGIT_W]),
            .q(bcd_next[i*BCD_DIGIT_W +: BCD_DIGIT_W])
        );
    end

`ifdef BCD_CHECK_EN
    logic [NUM_DIGITS-1:0] bad;
    logic                  err_reg, err_out;
    for (i = 0; i < NUM_DIGITS; i++) begin : g_chk
        assign bad[i] = !is_bcd_digit(in_bcd[i*BCD_DIGIT_W +: BCD_DIGIT_W]);
    end
    assign out_err = err_out;
`else
    assign out_err = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            out_bin   <= '0;
            cnt       <= '0;
            bcd_reg   <= '0;
            bin_reg   <= '0;
`ifdef BCD_CHECK_EN
            err_reg   <= 1'b0;
            err_out   <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: if (in_valid && in_ready) begin
                    bcd_reg  <= in_bcd;
                    bin_reg  <= '0;
                    cnt      <= '0;
                    in_ready <= 1'b0;
                    state    <= CONV;
`ifdef BCD_CHECK_EN
                    err_reg  <= |bad;
`endif
                end
                CONV: begin
                    bcd_reg <= bcd_next;
                    bin_reg <= bin_next;
                    cnt     <= cnt + CW'(1);
                    // last iteration publishes the combinational result directly
                    if (cnt == LAST) begin
                        state     <= DONE;
                        out_valid <= 1'b1;
`ifdef BCD_CHECK_EN
                        out_bin   <= err_reg ? '0 : bin_next;
                        err_out   <= err_reg;
`else
                        out_bin   <= bin_next;
`endif
                    end
                end
                DONE: if (out_ready) begin
                    state     <= IDLE;
                    out_valid <= 1'b0;
                    in_ready  <= 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_bcd_decoder_seq.sv
// tb_bcd_decoder_seq: directed checks of bcd_decoder_seq with NUM_DIGITS=2
module tb_bcd_decoder_seq;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [7:0] in_bcd = 8'h00;
    logic       out_valid;
    logic       out_ready = 1'b1;
    logic [6:0] out_bin;
    logic       out_err;

    int checks = 0;
    int errors = 0;
    int lat;

    bcd_decoder_seq #(.NUM_DIGITS(2)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_bcd(in_bcd), .out_valid(out_valid), .out_ready(out_ready),
        .out_bin(out_bin), .out_err(out_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic accept(input logic [7:0] b);
        chk("in_ready_before_accept", 32'(in_ready), 1);
        in_bcd = b;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
    endtask

    task automatic wait_done(input int start, output int n);
        n = start;
        while (!out_valid && n < 20) begin
            step();
            n++;
            chk("in_ready_busy", 32'(in_ready), 0);
        end
    endtask

    task automatic take();
        step();
        chk("out_valid_drop", 32'(out_valid), 0);
        chk("in_ready_back", 32'(in_ready), 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) step();
        chk("rst_in_ready", 32'(in_ready), 1);
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_out_bin", 32'(out_bin), 0);
        chk("rst_out_err", 32'(out_err), 0);
        rst_n = 1'b1;
        step();

        // 42 with latency check
        accept(8'h42);
        wait_done(0, lat);
        chk("lat_42", lat, 7);
        chk("bin_42", 32'(out_bin), 42);
        chk("err_42", 32'(out_err), 0);
        take();

        // back-to-back sweep of all legal words
        for (int v = 0; v < 100; v++) begin
            accept({4'(v / 10), 4'(v % 10)});
            wait_done(0, lat);
            chk("sweep_lat", lat, 7);
            chk("sweep_bin", 32'(out_bin), v);
            chk("sweep_err", 32'(out_err), 0);
            take();
        end

        // backpressure on 99
        out_ready = 1'b0;
        accept(8'h99);
        wait_done(0, lat);
        chk("lat_99", lat, 7);
        repeat (5) begin
            step();
            chk("hold_valid", 32'(out_valid), 1);
            chk("hold_bin", 32'(out_bin), 99);
            chk("hold_in_ready", 32'(in_ready), 0);
        end
        out_ready = 1'b1;
        take();
        step();
        chk("single_handshake", 32'(out_valid), 0);

        // illegal digit
        accept(8'h1A);
        wait_done(0, lat);
        chk("lat_1a", lat, 7);
`ifdef BCD_CHECK_EN
        chk("err_1a", 32'(out_err), 1);
        chk("bin_1a", 32'(out_bin), 0);
`else
        chk("err_1a", 32'(out_err), 0);
`endif
        take();

        // reset at third CONV cycle of 57
        accept(8'h57);
        repeat (2) step();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        chk("abort_in_ready", 32'(in_ready), 1);
        chk("abort_out_valid", 32'(out_valid), 0);
        repeat (8) begin
            step();
            chk("abort_stays_idle", 32'(out_valid), 0);
        end
        accept(8'h13);
        wait_done(0, lat);
        chk("lat_13", lat, 7);
        chk("bin_13", 32'(out_bin), 13);
        take();

        // in_valid pulse during CONV is ignored
        accept(8'h35);
        step();
        in_bcd = 8'h88;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        wait_done(2, lat);
        chk("lat_35", lat, 7);
        chk("bin_35", 32'(out_bin), 35);
        take();
        repeat (10) begin
            step();
            chk("no_extra_result", 32'(out_valid), 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
